// File: rtl/vz32_mem_arbiter.sv
// vz32_mem_arbiter: shares the single VZ32 memory port between instruction
// fetch (IF) and the load/store unit (LS). LS has priority. A streak counter
// limits how many consecutive LS grants can happen while IF is waiting.
// Memory side uses a registered req/ack handshake of arbitrary latency.
// Optional feature macro: VZ32_ARB_TIMEOUT_EN (abort a memory access that is
// not acknowledged within TIMEOUT busy cycles and flag it via if_err/ls_err).
module vz32_mem_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_LS_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    output logic            if_err,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wstrb,
    output logic [DW-1:0]   ls_rdata,
    output logic            ls_done,
    output logic            ls_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);

    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic            if_done_q, if_done_d;
    logic            ls_done_q, ls_done_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   ls_rdata_q, ls_rdata_d;

    // A port that is completing this cycle still shows its old request, so
    // it must not be granted again.
    logic if_vld, ls_vld, streak_max, grant_ls, busy_ls;
    assign if_vld     = if_req & ~if_done_q;
    assign ls_vld     = ls_req & ~ls_done_q;
    assign streak_max = (streak_q == SW'(MAX_LS_STREAK));
    assign grant_ls   = ls_vld & ~(if_vld & streak_max);
    assign busy_ls    = (state_q == BUSY_LS);

`ifdef VZ32_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          if_err_q, if_err_d;
    logic          ls_err_q, ls_err_d;
    logic          timeout;
    // Fires on the busy cycle that would bring the count up to TIMEOUT.
    assign timeout = (wait_q == TW'(TIMEOUT - 1));
`endif

    // State and output registers; reset abandons any transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
`ifdef VZ32_ARB_TIMEOUT_EN
            wait_q      <= '0;
            if_err_q    <= 1'b0;
            ls_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
`ifdef VZ32_ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            if_err_q    <= if_err_d;
            ls_err_q    <= ls_err_d;
`endif
        end
    end

    // Grant selection in IDLE, completion handling in BUSY.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
`ifdef VZ32_ARB_TIMEOUT_EN
        wait_d      = wait_q;
        if_err_d    = 1'b0;
        ls_err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef VZ32_ARB_TIMEOUT_EN
                wait_d = '0;
`endif
                if (grant_ls) begin
                    state_d     = BUSY_LS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    mem_wstrb_d = ls_wstrb;
                    if (!if_vld)         streak_d = '0;
                    else if (!streak_max) streak_d = streak_q + 1'b1;
                end else if (if_vld) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    streak_d    = '0;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (busy_ls) begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = mem_we_q ? '0 : mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
`ifdef VZ32_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (busy_ls) begin
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
`ifdef VZ32_ARB_TIMEOUT_EN
    assign if_err    = if_err_q;
    assign ls_err    = ls_err_q;
`else
    assign if_err    = 1'b0;
    assign ls_err    = 1'b0;
`endif

endmodule

// File: tb/tb_vz32_mem_arbiter.sv
// Self-checking bench for vz32_mem_arbiter: a vector table, directed
// multi-cycle sequences (slow memory, async reset, starvation) and a
// randomized run checked against a transaction-level reference model.
module tb_vz32_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_wstrb;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic        if_done, if_err, ls_done, ls_err, mem_req, mem_we;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;

    vz32_mem_arbiter #(.AW(32), .DW(32), .MAX_LS_STREAK(MAXS), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // expected outputs
    logic        e_mem_req, e_mem_we, e_if_done, e_ls_done;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_ls_rdata;
    logic [3:0]  e_mem_wstrb;

    typedef struct {
        logic        ifq;  logic [31:0] ia;
        logic        lsq;  logic we; logic [31:0] la; logic [31:0] wd; logic [3:0] ws;
        logic        ack;  logic [31:0] rd;
        logic        mreq; logic mwe; logic [31:0] maddr; logic [31:0] mwd; logic [3:0] mws;
        logic        ifd;  logic [31:0] ifr;
        logic        lsd;  logic [31:0] lsr;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm);
        checks++;
        if (mem_req !== e_mem_req || mem_we !== e_mem_we || mem_addr !== e_mem_addr ||
            mem_wdata !== e_mem_wdata || mem_wstrb !== e_mem_wstrb ||
            if_done !== e_if_done || if_rdata !== e_if_rdata || if_err !== 1'b0 ||
            ls_done !== e_ls_done || ls_rdata !== e_ls_rdata || ls_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got req=%b we=%b addr=%h wd=%h ws=%h ifd=%b ifr=%h ife=%b lsd=%b lsr=%h lse=%b | want req=%b we=%b addr=%h wd=%h ws=%h ifd=%b ifr=%h lsd=%b lsr=%h errs=0",
                     nm, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_done, if_rdata, if_err,
                     ls_done, ls_rdata, ls_err, e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata,
                     e_mem_wstrb, e_if_done, e_if_rdata, e_ls_done, e_ls_rdata);
        end
    endtask

    task automatic chk1(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic clear_exp();
        e_mem_req = 1'b0; e_mem_we = 1'b0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_wstrb = '0;
        e_if_done = 1'b0; e_if_rdata = '0; e_ls_done = 1'b0; e_ls_rdata = '0;
    endtask

    task automatic clear_in();
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
        ls_wdata = '0; ls_wstrb = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Reference model: who owns the memory port, and how many LS grants in a
    // row have been given while IF was left waiting.
    int m_owner;   // 0 free, 1 IF, 2 LS
    int m_streak;

    task automatic model_step();
        logic pi, pl;
        pi = if_req && !e_if_done;   // a port finishing now is not re-served
        pl = ls_req && !e_ls_done;
        e_if_done = 1'b0;
        e_ls_done = 1'b0;
        if (m_owner != 0) begin
            if (mem_ack) begin
                if (m_owner == 1) begin
                    e_if_done = 1'b1; e_if_rdata = mem_rdata;
                end else begin
                    e_ls_done = 1'b1; e_ls_rdata = e_mem_we ? 32'h0 : mem_rdata;
                end
                e_mem_req = 1'b0;
                m_owner   = 0;
            end
        end else if (pl && !(pi && m_streak == MAXS)) begin
            m_owner = 2; e_mem_req = 1'b1; e_mem_we = ls_we; e_mem_addr = ls_addr;
            e_mem_wdata = ls_wdata; e_mem_wstrb = ls_wstrb;
            m_streak = pi ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (pi) begin
            m_owner = 1; e_mem_req = 1'b1; e_mem_we = 1'b0; e_mem_addr = if_addr;
            e_mem_wdata = '0; e_mem_wstrb = '0;
            m_streak = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int ls_cnt, if_seen, resumed;
        bit if_act, ls_act;
        int if_wait, ls_wait;

        clear_in();
        clear_exp();
        do_reset();
        chk("reset");

        // ---- vector table ----
        tbl[0]  = '{1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,
                    1'b1,1'b0,32'h100,32'h0,4'h0, 1'b0,32'h0, 1'b0,32'h0};
        tbl[1]  = '{1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'hA5A5A5A5,
                    1'b0,1'b0,32'h100,32'h0,4'h0, 1'b1,32'hA5A5A5A5, 1'b0,32'h0};
        tbl[2]  = '{1'b1,32'h100, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,
                    1'b0,1'b0,32'h100,32'h0,4'h0, 1'b0,32'hA5A5A5A5, 1'b0,32'h0};
        tbl[3]  = '{1'b1,32'h300, 1'b1,1'b1,32'h200,32'h12345678,4'hF, 1'b0,32'h0,
                    1'b1,1'b1,32'h200,32'h12345678,4'hF, 1'b0,32'hA5A5A5A5, 1'b0,32'h0};
        tbl[4]  = '{1'b1,32'h300, 1'b1,1'b1,32'h200,32'h12345678,4'hF, 1'b1,32'hDEADBEEF,
                    1'b0,1'b1,32'h200,32'h12345678,4'hF, 1'b0,32'hA5A5A5A5, 1'b1,32'h0};
        tbl[5]  = '{1'b1,32'h300, 1'b1,1'b1,32'h200,32'h12345678,4'hF, 1'b0,32'h0,
                    1'b1,1'b0,32'h300,32'h0,4'h0, 1'b0,32'hA5A5A5A5, 1'b0,32'h0};
        tbl[6]  = '{1'b1,32'h300, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h0BADF00D,
                    1'b0,1'b0,32'h300,32'h0,4'h0, 1'b1,32'h0BADF00D, 1'b0,32'h0};
        tbl[7]  = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,
                    1'b0,1'b0,32'h300,32'h0,4'h0, 1'b0,32'h0BADF00D, 1'b0,32'h0};
        tbl[8]  = '{1'b0,32'h0, 1'b1,1'b0,32'h40,32'h55,4'h3, 1'b0,32'h0,
                    1'b1,1'b0,32'h40,32'h55,4'h3, 1'b0,32'h0BADF00D, 1'b0,32'h0};
        tbl[9]  = '{1'b0,32'h0, 1'b1,1'b0,32'h40,32'h55,4'h3, 1'b1,32'hCAFEF00D,
                    1'b0,1'b0,32'h40,32'h55,4'h3, 1'b0,32'h0BADF00D, 1'b1,32'hCAFEF00D};
        tbl[10] = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h11111111,
                    1'b0,1'b0,32'h40,32'h55,4'h3, 1'b0,32'h0BADF00D, 1'b0,32'hCAFEF00D};
        tbl[11] = '{1'b0,32'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,
                    1'b0,1'b0,32'h40,32'h55,4'h3, 1'b0,32'h0BADF00D, 1'b0,32'hCAFEF00D};

        for (int i = 0; i < 12; i++) begin
            if_req = tbl[i].ifq; if_addr = tbl[i].ia;
            ls_req = tbl[i].lsq; ls_we = tbl[i].we; ls_addr = tbl[i].la;
            ls_wdata = tbl[i].wd; ls_wstrb = tbl[i].ws;
            mem_ack = tbl[i].ack; mem_rdata = tbl[i].rd;
            @(posedge clk); #1;
            e_mem_req = tbl[i].mreq; e_mem_we = tbl[i].mwe; e_mem_addr = tbl[i].maddr;
            e_mem_wdata = tbl[i].mwd; e_mem_wstrb = tbl[i].mws;
            e_if_done = tbl[i].ifd; e_if_rdata = tbl[i].ifr;
            e_ls_done = tbl[i].lsd; e_ls_rdata = tbl[i].lsr;
            chk($sformatf("vec%0d", i));
        end
        clear_in();

        // ---- slow memory: ack after 10 waiting cycles ----
        if_req = 1'b1; if_addr = 32'h500;
        @(posedge clk); #1;
        chk1("slow_grant_req", 32'(mem_req), 32'h1);
        chk1("slow_grant_addr", mem_addr, 32'h500);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h500 || mem_we !== 1'b0 || if_done !== 1'b0) begin
                errors++;
                $display("FAIL slow_hold%0d: req=%b addr=%h we=%b ifd=%b want 1/500/0/0",
                         i, mem_req, mem_addr, mem_we, if_done);
            end
        end
        mem_ack = 1'b1; mem_rdata = 32'h77;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk1("slow_done", 32'(if_done), 32'h1);
        chk1("slow_rdata", if_rdata, 32'h77);
        chk1("slow_req_drop", 32'(mem_req), 32'h0);
        @(posedge clk); #1;   // if_req still high here: must not be re-granted
        chk1("slow_no_regrant", 32'(mem_req), 32'h0);
        chk1("slow_single_pulse", 32'(if_done), 32'h0);
        if_req = 1'b0;
        @(posedge clk); #1;

        // ---- async reset during BUSY_LS ----
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600;
        @(posedge clk); #1;
        chk1("rst_busy_ls", 32'(mem_req), 32'h1);
        if_req = 1'b1; if_addr = 32'h700;
        @(negedge clk); #2 rst = 1'b1;
        #1;
        clear_exp();
        chk("rst_async_clear");
        ls_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk1("rst_no_ls_done", 32'(ls_done), 32'h0);
        chk1("rst_if_grant", {mem_req, mem_we, mem_addr[29:0]}, {1'b1, 1'b0, 30'h700});
        mem_ack = 1'b1; mem_rdata = 32'h99;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk1("rst_if_done", {31'h0, if_done}, 32'h1);
        chk1("rst_if_rdata", if_rdata, 32'h99);
        if_req = 1'b0;
        @(posedge clk); #1;

        // ---- starvation guard: LS keeps requesting while IF waits ----
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h1000; ls_wdata = 32'h1; ls_wstrb = 4'hF;
        if_req = 1'b1; if_addr = 32'h800;
        ls_cnt = 0; if_seen = 0; resumed = 0;
        for (int c = 0; c < 200 && resumed == 0; c++) begin
            @(posedge clk); #1;
            if (ls_done && if_done) begin
                errors++; $display("FAIL starve_both_done: if_done=1 ls_done=1 want at most one");
            end
            if (ls_done) begin
                if (if_seen) resumed = 1; else ls_cnt++;
                ls_addr = ls_addr + 32'h4;
            end
            if (if_done) begin
                if_seen = 1; if_req = 1'b0;
            end
            mem_ack = mem_req;
        end
        mem_ack = 1'b0;
        chk1("starve_if_served", 32'(if_seen), 32'h1);
        checks++;
        if (ls_cnt < 1 || ls_cnt > MAXS) begin
            errors++; $display("FAIL starve_ls_count: got %0d LS before IF want 1..%0d", ls_cnt, MAXS);
        end
        chk1("starve_ls_resumes", 32'(resumed), 32'h1);
        clear_in();
        repeat (3) @(posedge clk);
        #1;

        // ---- randomized run against the reference model ----
        do_reset();
        clear_exp();
        m_owner = 0; m_streak = 0;
        if_act = 0; ls_act = 0; if_wait = 0; ls_wait = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            model_step();
            chk("rand");
            if (e_if_done) begin if_act = 0; if_wait = 0; end
            if (e_ls_done) begin ls_act = 0; ls_wait = 0; end
            if (!if_act && ($urandom % 3 == 0)) begin
                if_act = 1; if_addr = $urandom;
            end
            if (!ls_act && ($urandom % 3 == 0)) begin
                ls_act = 1; ls_we = 1'($urandom); ls_addr = $urandom;
                ls_wdata = $urandom; ls_wstrb = 4'($urandom);
            end
            if_req = if_act; ls_req = ls_act;
            if (if_act) if_wait++;
            if (ls_act) ls_wait++;
            if (if_wait > 300) begin
                errors++; $display("FAIL rand_if_starved: waited %0d cycles want <=300", if_wait); if_wait = 0;
            end
            if (ls_wait > 300) begin
                errors++; $display("FAIL rand_ls_starved: waited %0d cycles want <=300", ls_wait); ls_wait = 0;
            end
            mem_ack   = e_mem_req ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
            mem_rdata = $urandom;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
